// File: rtl/tx_mac_lite_frame_arbiter_pkg.sv
// Shared types and width helpers for the TX MAC Lite per-frame arbiter.
// Pure declarations; no logic, no latency.
package tx_mac_lite_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // A one-entry range still needs a 1-bit index.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int eofw_calc(input int region_size, input int block_size);
        return safe_clog2(region_size * block_size);
    endfunction

endpackage

// File: rtl/tx_mac_lite_frame_arbiter_if.sv
// MFB-style word bus bundling CH parallel lanes; master drives the word, slave returns dst_rdy.
// Transfer on a lane happens when src_rdy & dst_rdy are both high at the clock edge.
interface tx_mac_lite_frame_arbiter_if #(
    parameter int CH         = 1,
    parameter int DATA_WIDTH = 512,
    parameter int EOFW       = 6
);
    logic [CH-1:0][DATA_WIDTH-1:0] data;
    logic [CH-1:0]                 sof;
    logic [CH-1:0]                 eof;
    logic [CH-1:0][EOFW-1:0]       eof_pos;
    logic [CH-1:0]                 src_rdy;
    logic [CH-1:0]                 dst_rdy;

    modport master (
        output data, sof, eof, eof_pos, src_rdy,
        input  dst_rdy
    );

    modport slave (
        input  data, sof, eof, eof_pos, src_rdy,
        output dst_rdy
    );
endinterface

// File: rtl/tx_mac_lite_frame_arbiter_rr_arb_pick.sv
// Combinational rotating-priority pick: first set request strictly after i_ptr, with wrap.
// Zero latency; no handshake.
module rr_arb_pick
    import tx_mac_lite_arb_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int IW       = safe_clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [IW-1:0]       i_ptr,
    output logic                o_vld,
    output logic [IW-1:0]       o_idx,
    output logic [CHANNELS-1:0] o_onehot
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_vld    = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_cand   = '0;
        // k = CHANNELS revisits i_ptr itself, so the last-served channel has lowest priority.
        for (int k = 1; k <= CHANNELS; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % CHANNELS);
            if (!o_vld && i_req[w_cand]) begin
                o_vld = 1'b1;
                o_idx = w_cand;
            end
        end
        if (o_vld) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tx_mac_lite_frame_arbiter.sv
// Per-frame round-robin mux of CHANNELS MFB sources onto one TX MAC Lite input; 1-cycle bubble per grant,
// zero-latency data path once granted; TX backpressure stalls only the granted source, strays drain in IDLE.
module tx_mac_lite_frame_arbiter
    import tx_mac_lite_arb_pkg::*;
#(
    parameter  int CHANNELS    = 4,
    parameter  int REGION_SIZE = 8,
    parameter  int BLOCK_SIZE  = 8,
    parameter  int ITEM_WIDTH  = 8,
    localparam int DATA_WIDTH  = REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH,
    localparam int EOFW        = eofw_calc(REGION_SIZE, BLOCK_SIZE),
    localparam int GW          = safe_clog2(CHANNELS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [CHANNELS-1:0]         i_ch_en,
    tx_mac_lite_frame_arbiter_if.slave  rx,
    tx_mac_lite_frame_arbiter_if.master tx,
    output logic [GW-1:0]               o_grant_ch,
    output logic [CHANNELS-1:0]         o_err_stray
);

    state_t              r_state;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_ptr;
    logic [CHANNELS-1:0] r_grant_oh;

    logic [CHANNELS-1:0] w_elig;
    logic                w_pick_vld;
    logic [GW-1:0]       w_pick_idx;
    logic [CHANNELS-1:0] w_pick_oh;
    logic                w_xfer;
    logic                w_eof_fire;
    logic [CHANNELS-1:0] w_stray;
    logic [DATA_WIDTH-1:0] w_tx_data;
    logic [EOFW-1:0]     w_tx_pos;

    assign w_elig = rx.src_rdy & rx.sof & i_ch_en;

    rr_arb_pick #(
        .CHANNELS (CHANNELS)
    ) u_pick (
        .i_req    (w_elig),
        .i_ptr    (r_ptr),
        .o_vld    (w_pick_vld),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_oh)
    );

    assign w_xfer     = (r_state == XFER);
    assign w_eof_fire = w_xfer & rx.src_rdy[r_grant] & tx.dst_rdy[0] & rx.eof[r_grant];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= GW'(CHANNELS - 1);
            r_grant_oh <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_state    <= XFER;
                        r_grant    <= w_pick_idx;
                        r_ptr      <= w_pick_idx;
                        r_grant_oh <= w_pick_oh;
                    end
                end
                XFER: begin
                    if (w_eof_fire) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stray words are only recognised between frames; inside a frame every word belongs to the owner.
    assign w_stray = (!i_rst && !w_xfer) ? (rx.src_rdy & ~rx.sof) : '0;

    assign w_tx_data = rx.data[r_grant];
    assign w_tx_pos  = rx.eof_pos[r_grant];

    assign tx.data[0]    = w_tx_data;
    assign tx.eof_pos[0] = w_tx_pos;
    assign tx.sof[0]     = rx.sof[r_grant];
    assign tx.eof[0]     = rx.eof[r_grant];
    assign tx.src_rdy[0] = w_xfer & rx.src_rdy[r_grant];

    assign rx.dst_rdy  = w_stray | (w_xfer ? (r_grant_oh & {CHANNELS{tx.dst_rdy[0]}}) : '0);
    assign o_err_stray = w_stray;
    assign o_grant_ch  = r_grant;

endmodule

// File: tb/tb_tx_mac_lite_frame_arbiter.sv
// Directed bench: per-channel frame sources plus a frame-level round-robin model checked every cycle.
module tb_tx_mac_lite_frame_arbiter;
    import tx_mac_lite_arb_pkg::*;

    localparam int CH = 4;
    localparam int DW = 512;
    localparam int EW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] ch_en;
    logic [1:0]    grant;
    logic [CH-1:0] err;

    always #5 clk = ~clk;

    tx_mac_lite_frame_arbiter_if #(.CH(CH), .DATA_WIDTH(DW), .EOFW(EW)) rx_if ();
    tx_mac_lite_frame_arbiter_if #(.CH(1),  .DATA_WIDTH(DW), .EOFW(EW)) tx_if ();

    tx_mac_lite_frame_arbiter #(
        .CHANNELS(CH), .REGION_SIZE(8), .BLOCK_SIZE(8), .ITEM_WIDTH(8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ch_en     (ch_en),
        .rx          (rx_if),
        .tx          (tx_if),
        .o_grant_ch  (grant),
        .o_err_stray (err)
    );

    // Source state: frame length, frames left, word index, frame number, pending stray word.
    int s_len [CH];
    int s_left[CH];
    int s_widx[CH];
    int s_fnum[CH];
    bit s_stray[CH];
    bit tx_rdy;

    // Model: owner of the output (-1 = none), last channel served, logs of grants and TX word owners.
    int m_owner = -1;
    int m_last  = CH - 1;
    int glog[$];
    int tlog[$];
    logic [CH-1:0] fire;
    logic [CH-1:0] stray_m;
    logic [CH-1:0] elig_m;
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int tx_words = 0, tx_sofs = 0, tx_eofs = 0;
    int err_cycles = 0;
    logic [CH-1:0] err_last;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string nm, input int got[$], input int exp[$]);
        chk({nm, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s_%0d", nm, i), got[i], exp[i]);
    endtask

    function automatic logic [DW-1:0] mk_data(input int i);
        logic [31:0] w;
        if (s_stray[i]) w = {8'(i), 8'hEE, 8'hEE, 8'h5A};
        else            w = {8'(i), 8'(s_fnum[i]), 8'(s_widx[i]), 8'hA5};
        return {16{w}};
    endfunction

    function automatic logic [EW-1:0] mk_pos(input int i);
        return EW'(i * 13 + s_widx[i] * 5 + s_fnum[i]);
    endfunction

    function automatic bit mk_sof(input int i);
        return !s_stray[i] && s_widx[i] == 0;
    endfunction

    function automatic bit mk_eof(input int i);
        return !s_stray[i] && s_widx[i] == s_len[i] - 1;
    endfunction

    function automatic bit all_done();
        bit d = (m_owner < 0);
        for (int i = 0; i < CH; i++) if (s_left[i] != 0 || s_stray[i]) d = 0;
        return d;
    endfunction

    task automatic drive();
        for (int i = 0; i < CH; i++) begin
            rx_if.src_rdy[i] = s_stray[i] || s_left[i] > 0;
            rx_if.data[i]    = mk_data(i);
            rx_if.sof[i]     = mk_sof(i);
            rx_if.eof[i]     = mk_eof(i);
            rx_if.eof_pos[i] = mk_pos(i);
        end
        tx_if.dst_rdy[0] = tx_rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < CH; i++) begin
            if (fire[i]) begin
                if (s_stray[i]) s_stray[i] = 0;
                else begin
                    s_widx[i]++;
                    if (s_widx[i] == s_len[i]) begin
                        s_widx[i] = 0;
                        s_fnum[i]++;
                        s_left[i]--;
                    end
                end
            end
        end
        drive();
    endtask

    task automatic run_until(input string nm, input int budget);
        int n = 0;
        while (!all_done() && n < budget) begin
            tick();
            n++;
        end
        chk(nm, all_done(), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        glog.delete();
        tlog.delete();
        tx_words = 0; tx_sofs = 0; tx_eofs = 0;
        err_cycles = 0; err_last = '0;
    endtask

    // Compare + model step; inputs are stable from posedge+1 until the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_tx_vld", tx_if.src_rdy[0], 0);
            chk("rst_dst_rdy", rx_if.dst_rdy, 0);
            chk("rst_err", err, 0);
            m_owner = -1;
            m_last  = CH - 1;
            fire    = '0;
        end else begin
            fire = rx_if.src_rdy & rx_if.dst_rdy;
            if (tx_if.src_rdy[0] && tx_if.dst_rdy[0]) begin
                tx_words++;
                if (tx_if.sof[0]) tx_sofs++;
                if (tx_if.eof[0]) tx_eofs++;
                tlog.push_back(m_owner);
            end
            if (err != 0) begin
                err_cycles++;
                err_last = err;
            end
            if (m_owner < 0) begin
                stray_m = rx_if.src_rdy & ~rx_if.sof;
                chk("idle_tx_vld", tx_if.src_rdy[0], 0);
                chk("idle_dst_rdy", rx_if.dst_rdy, stray_m);
                chk("idle_err", err, stray_m);
                elig_m = rx_if.src_rdy & rx_if.sof & ch_en;
                for (int k = 1; k <= CH; k++) begin
                    if (m_owner < 0 && elig_m[(m_last + k) % CH]) begin
                        m_owner = (m_last + k) % CH;
                        m_last  = m_owner;
                        glog.push_back(m_owner);
                    end
                end
            end else begin
                chk("xfer_grant", grant, m_owner);
                chk("xfer_tx_vld", tx_if.src_rdy[0], rx_if.src_rdy[m_owner]);
                chk("xfer_dst_rdy", rx_if.dst_rdy, tx_rdy ? (CH'(1) << m_owner) : '0);
                chk("xfer_err", err, 0);
                if (rx_if.src_rdy[m_owner]) begin
                    chk("xfer_data", tx_if.data[0], mk_data(m_owner));
                    chk("xfer_sof", tx_if.sof[0], mk_sof(m_owner));
                    chk("xfer_eof", tx_if.eof[0], mk_eof(m_owner));
                    chk("xfer_pos", tx_if.eof_pos[0], mk_pos(m_owner));
                    if (tx_rdy && mk_eof(m_owner)) m_owner = -1;
                end
            end
        end
    end

    initial begin
        int e[$];
        int t0;
        for (int i = 0; i < CH; i++) begin
            s_len[i] = 1; s_left[i] = 0; s_widx[i] = 0; s_fnum[i] = 0; s_stray[i] = 0;
        end
        ch_en  = 4'hF;
        tx_rdy = 1'b1;
        fire   = '0;
        drive();
        do_reset();

        // 1: single 3-word frame on ch1
        s_len[1] = 3; s_left[1] = 1; drive();
        t0 = cyc;
        chk("t1_bubble", tx_if.src_rdy[0], 0);
        tick();
        chk("t1_w0_vld", tx_if.src_rdy[0], 1);
        chk("t1_w0_sof", tx_if.sof[0], 1);
        chk("t1_grant", grant, 1);
        run_until("t1_done", 20);
        chk("t1_cycles", cyc - t0, 4);
        chk("t1_words", tx_words, 3);
        chk("t1_sofs", tx_sofs, 1);
        chk("t1_eofs", tx_eofs, 1);
        e = '{1};
        chk_q("t1_order", glog, e);

        // 2: all channels offer two 1-word frames each
        do_reset();
        for (int i = 0; i < CH; i++) begin s_len[i] = 1; s_left[i] = 2; end
        drive();
        t0 = cyc;
        run_until("t2_done", 40);
        chk("t2_cycles", cyc - t0, 16);
        chk("t2_words", tx_words, 8);
        e = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_q("t2_order", glog, e);

        // 3: ch0 5-word frame under toggling backpressure, ch2 requests mid-frame
        do_reset();
        s_len[0] = 5; s_left[0] = 1; drive();
        tick();
        tick();
        s_len[2] = 2; s_left[2] = 1; drive();
        for (int n = 0; n < 60 && !all_done(); n++) begin
            tx_rdy = ~tx_rdy;
            drive();
            tick();
        end
        chk("t3_done", all_done(), 1);
        tx_rdy = 1'b1; drive();
        e = '{0, 2};
        chk_q("t3_grants", glog, e);
        e = '{0, 0, 0, 0, 0, 2, 2};
        chk_q("t3_words", tlog, e);

        // 4: ch2 disabled never wins; ch0 loses enable mid-frame but completes
        do_reset();
        ch_en = 4'b1011;
        s_len[2] = 1; s_left[2] = 3;
        s_len[0] = 4; s_left[0] = 1;
        drive();
        tick();
        tick();
        ch_en = 4'b1010;
        repeat (10) tick();
        e = '{0};
        chk_q("t4_grants", glog, e);
        e = '{0, 0, 0, 0};
        chk_q("t4_words", tlog, e);
        chk("t4_ch2_pending", s_left[2], 3);
        s_left[2] = 0; drive();
        ch_en = 4'hF;
        tick();

        // 5: stray on ch3 coincides with SOF on ch1
        do_reset();
        s_stray[3] = 1;
        s_len[1] = 2; s_left[1] = 1;
        drive();
        run_until("t5_done", 20);
        chk("t5_err_cycles", err_cycles, 1);
        chk("t5_err_value", err_last, 4'b1000);
        e = '{1};
        chk_q("t5_grants", glog, e);
        e = '{1, 1};
        chk_q("t5_words", tlog, e);

        // 6: reset during word 2 of a 5-word frame
        do_reset();
        s_len[0] = 5; s_left[0] = 1;
        s_len[1] = 1; s_left[1] = 1;
        drive();
        for (int n = 0; n < 20 && s_widx[0] != 2; n++) tick();
        chk("t6_reach_w2", s_widx[0], 2);
        chk("t6_pre_vld", tx_if.src_rdy[0], 1);
        rst = 1'b1;
        s_widx[0] = 0;
        drive();
        #1;
        chk("t6_rst_tx_vld", tx_if.src_rdy[0], 0);
        chk("t6_rst_dst", rx_if.dst_rdy, 0);
        tick();
        tick();
        glog.delete();
        tlog.delete();
        rst = 1'b0;
        run_until("t6_done", 30);
        e = '{0, 1};
        chk_q("t6_grants", glog, e);
        e = '{0, 0, 0, 0, 0, 1};
        chk_q("t6_words", tlog, e);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
